// File: rtl/tb_mon_pkg.sv
// Shared definitions for the end-of-test monitor: datapath widths,
// FSM state encoding and the halt repeat-counter update rule.
package tb_mon_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 1 << REG_IDX_W;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_PASS  = 2'd2,
        ST_FAIL  = 2'd3
    } mon_state_t;

    // Next value of the same-PC repeat counter for a retiring instruction.
    // A zero counter means nothing has retired since reset, so the first
    // retirement always starts a fresh run of 1 regardless of the PC.
    function automatic logic [31:0] next_repeat(
        input logic [31:0] cur,
        input logic        same_pc,
        input logic [31:0] limit
    );
        if (cur == '0 || !same_pc) begin
            return 32'd1;
        end else if (cur >= limit) begin
            return limit;
        end else begin
            return cur + 32'd1;
        end
    endfunction

endpackage

// File: rtl/shadow_regfile.sv
// Shadow copy of the CPU architectural registers x1..x31.
// One synchronous write port, one combinational read port; x0 reads 0.
module shadow_regfile
    import tb_mon_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_idx,
    input  logic [XLEN-1:0]      wr_data,
    input  logic [REG_IDX_W-1:0] rd_idx,
    output logic [XLEN-1:0]      rd_data
);

    logic [XLEN-1:0] regs [1:NUM_REGS-1];

    // Capture CPU register writes; writes to x0 are discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_idx != '0) begin
            regs[wr_idx] <= wr_data;
        end
    end

    // Combinational read; a write in the same cycle is not yet visible.
    always_comb begin
        rd_data = '0;
        if (rd_idx != '0) begin
            rd_data = regs[rd_idx];
        end
    end

endmodule

// File: rtl/test_monitor.sv
// End-of-test monitor: detects a CPU halt (same PC retired repeatedly),
// waits a drain period, then checks one shadowed register against an
// expected value. A cycle-count timeout forces a fail.
module test_monitor
    import tb_mon_pkg::*;
#(
    parameter logic [31:0] MAX_CYC     = 32'd1000,
    parameter logic [4:0]  CHECK_REG   = 5'd10,
    parameter logic [31:0] EXP_VAL     = 32'd45,
    parameter int unsigned HALT_REPEAT = 3,
    parameter int unsigned DRAIN_CYC   = 4
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          cyc_cnt,
    input  logic                 rf_wr_en,
    input  logic [REG_IDX_W-1:0] rf_wr_idx,
    input  logic [XLEN-1:0]      rf_wr_data,
    input  logic                 retire_valid,
    input  logic [XLEN-1:0]      retire_pc,
    output logic                 passed,
    output logic                 failed
);

    mon_state_t      state;
    logic [XLEN-1:0] prev_pc;
    logic [31:0]     rep_cnt;
    logic [31:0]     drain_cnt;
    logic [XLEN-1:0] check_val;
    logic            halt;
    logic            timeout;
    logic            check_ok;

    shadow_regfile u_shadow (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rf_wr_en),
        .wr_idx  (rf_wr_idx),
        .wr_data (rf_wr_data),
        .rd_idx  (CHECK_REG),
        .rd_data (check_val)
    );

    // Track consecutive retirements at the same PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pc <= '0;
            rep_cnt <= '0;
        end else if (retire_valid) begin
            prev_pc <= retire_pc;
            rep_cnt <= next_repeat(rep_cnt, retire_pc == prev_pc, HALT_REPEAT);
        end
    end

    // Decode halt, timeout and the end-of-test register comparison.
    always_comb begin
        halt     = (rep_cnt == HALT_REPEAT);
        timeout  = (cyc_cnt == MAX_CYC);
        check_ok = (check_val == EXP_VAL);
    end

    // Run/drain/verdict FSM. The verdict flags are set together with the
    // terminal state so they track it exactly. In DRAIN the expiry check is
    // tested before the timeout so the register comparison takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            passed    <= 1'b0;
            failed    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (timeout) begin
                        state  <= ST_FAIL;
                        failed <= 1'b1;
                    end else if (halt) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_CYC;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        if (check_ok) begin
                            state  <= ST_PASS;
                            passed <= 1'b1;
                        end else begin
                            state  <= ST_FAIL;
                            failed <= 1'b1;
                        end
                    end else if (timeout) begin
                        state  <= ST_FAIL;
                        failed <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 32'd1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_monitor.sv
// Directed bench for test_monitor. Four instances share the stimulus:
//   u0 default parameters, u1 checks x0 against 45,
//   u2 times out exactly at drain expiry, u3 times out exactly at halt.
module tb_test_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cyc_cnt;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_idx;
    logic [31:0] rf_wr_data;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic        p0, f0, p1, f1, p2, f2, p3, f3;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    test_monitor u0 (
        .clk(clk), .reset(reset), .cyc_cnt(cyc_cnt),
        .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
        .retire_valid(retire_valid), .retire_pc(retire_pc),
        .passed(p0), .failed(f0)
    );

    test_monitor #(.CHECK_REG(5'd0), .EXP_VAL(32'd45)) u1 (
        .clk(clk), .reset(reset), .cyc_cnt(cyc_cnt),
        .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
        .retire_valid(retire_valid), .retire_pc(retire_pc),
        .passed(p1), .failed(f1)
    );

    test_monitor #(.MAX_CYC(32'd10)) u2 (
        .clk(clk), .reset(reset), .cyc_cnt(cyc_cnt),
        .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
        .retire_valid(retire_valid), .retire_pc(retire_pc),
        .passed(p2), .failed(f2)
    );

    test_monitor #(.MAX_CYC(32'd5)) u3 (
        .clk(clk), .reset(reset), .cyc_cnt(cyc_cnt),
        .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
        .retire_valid(retire_valid), .retire_pc(retire_pc),
        .passed(p3), .failed(f3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; sample and drive 1 time unit after the edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc_cnt = cyc_cnt + 32'd1;
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        rf_wr_en     = 1'b0;
        rf_wr_idx    = '0;
        rf_wr_data   = '0;
        retire_valid = 1'b0;
        retire_pc    = '0;
        step(2);
        reset   = 1'b0;
        cyc_cnt = 32'd1;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
        rf_wr_en   = 1'b1;
        rf_wr_idx  = idx;
        rf_wr_data = data;
        step();
        rf_wr_en   = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc, input int n);
        retire_valid = 1'b1;
        retire_pc    = pc;
        step(n);
        retire_valid = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        cyc_cnt = '0;

        // Reset state
        do_reset();
        check("rst_passed", p0, 0);
        check("rst_failed", f0, 0);

        // Pass sequence: halt detected at cycle 5, verdict 6 cycles later
        write_reg(5'd10, 32'd45);
        retire(32'h40, 3);
        step();
        check("halt_timeout_failed", f3, 1);
        check("halt_timeout_passed", p3, 0);
        step(4);
        check("pass_not_early", p0, 0);
        step();
        check("pass_passed", p0, 1);
        check("pass_failed", f0, 0);
        check("expiry_timeout_passed", p2, 1);
        check("expiry_timeout_failed", f2, 0);
        write_reg(5'd10, 32'd0);
        retire(32'h80, 3);
        step(2);
        check("pass_sticky", p0, 1);
        check("pass_sticky_failed", f0, 0);

        // Reset from PASS
        reset = 1'b1;
        step();
        check("rst_from_pass", p0, 0);
        do_reset();

        // Wrong value
        write_reg(5'd10, 32'd44);
        retire(32'h40, 3);
        step(6);
        check("wrong_val_failed", f0, 1);
        check("wrong_val_passed", p0, 0);

        // No halt: fail the cycle after cyc_cnt reaches 1000
        do_reset();
        write_reg(5'd10, 32'd45);
        retire_valid = 1'b1;
        retire_pc    = 32'h100;
        for (int i = 0; i < 2000 && cyc_cnt != 32'd1000; i++) begin
            step();
            retire_pc = retire_pc + 32'd4;
        end
        check("timeout_not_early", f0, 0);
        step();
        retire_valid = 1'b0;
        check("timeout_failed", f0, 1);
        check("timeout_passed", p0, 0);

        // Write landing two cycles into DRAIN is seen
        do_reset();
        retire(32'h40, 3);
        step(2);
        write_reg(5'd10, 32'd45);
        step(3);
        check("late_write_passed", p0, 1);
        check("late_write_failed", f0, 0);

        // Write landing on the expiry cycle is not seen
        do_reset();
        retire(32'h40, 3);
        step(5);
        write_reg(5'd10, 32'd45);
        check("expiry_write_failed", f0, 1);
        check("expiry_write_passed", p0, 0);

        // x0 writes ignored
        do_reset();
        write_reg(5'd0, 32'd45);
        retire(32'h40, 3);
        step(6);
        check("x0_failed", f1, 1);
        check("x0_passed", p1, 0);

        // Reset mid-DRAIN, then a fresh pass sequence
        do_reset();
        write_reg(5'd10, 32'd45);
        retire(32'h40, 3);
        step(3);
        reset = 1'b1;
        step();
        check("mid_drain_rst_passed", p0, 0);
        check("mid_drain_rst_failed", f0, 0);
        reset   = 1'b0;
        cyc_cnt = 32'd1;
        write_reg(5'd10, 32'd45);
        retire(32'h40, 2);
        step(8);
        check("halt_cnt_cleared", p0, 0);
        check("halt_cnt_cleared_f", f0, 0);
        retire(32'h40, 1);
        step(5);
        check("fresh_not_early", p0, 0);
        step();
        check("fresh_passed", p0, 1);
        check("fresh_failed", f0, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
